pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined LEGv8 core.
//  Drives their enable lines and requests ID/EX bubbles and IF/ID flushes.
//  Covers three cases: load-use hazards, taken-branch squash, and multi-cycle data-memory waits.
//  Sits beside the decode stage; every pipeline register takes its enable from this block.
// PARAMETERS
//  BR_PENALTY  1   cycles IF/ID+ID/EX are squashed after branch_taken (1..3)
//  MEM_TIMEOUT 15  max consecutive mem-wait cycles before err_timeout (1..255)
// PORTS
//  clk           in   1  core clock, all state on rising edge
//  rst           in   1  synchronous, active-high reset
//  idex_mem_read in   1  ID/EX holds a load (MemRead)
//  idex_rd       in   5  ID/EX destination register
//  ifid_rn       in   5  IF/ID source Rn
//  ifid_rm       in   5  IF/ID source Rm
//  ifid_uses_rm  in   1  IF/ID instruction reads Rm (0 for imm/CBZ forms)
//  branch_taken  in   1  branch resolved taken this cycle (from EX/MEM)
//  mem_req       in   1  MEM stage is accessing data memory
//  mem_ready     in   1  data memory completes access this cycle
//  pc_en         out  1  PC register enable
//  ifid_en       out  1  IF/ID enable
//  ifid_flush    out  1  IF/ID loads NOP
//  idex_en       out  1  ID/EX enable
//  idex_bubble   out  1  ID/EX loads all-zero cntrl_EX/M/WB
//  exmem_en      out  1  EX/MEM enable
//  memwb_en      out  1  MEM/WB enable
//  err_timeout   out  1  sticky: memory wait exceeded MEM_TIMEOUT
// BEHAVIOUR
//  State register st in {RUN, FLUSH, MEM_WAIT}.
//  Counters: flush_cnt [1:0], wait_cnt [7:0]. Both are registered.
//  Outputs are combinational from st and the current inputs, so stalls take effect in the same cycle.
//  Reset (rst=1 at edge): st=RUN, counters=0, err_timeout=0.
//  Outputs while rst=1: all *_en=0, ifid_flush=1, idex_bubble=1.
//  hazard = idex_mem_read & idex_rd!=31 & (idex_rd==ifid_rn | (ifid_uses_rm & idex_rd==ifid_rm)).
//  X31 (XZR) never hazards.
//  Priority: memory wait > branch > load-use.
//  RUN:
//   - mem_req & ~mem_ready: all *_en=0 (full freeze). Next st=MEM_WAIT, wait_cnt=1.
//   - else if branch_taken: all *_en=1, ifid_flush=1, idex_bubble=1.
//     Next st=FLUSH with flush_cnt=BR_PENALTY-1; if BR_PENALTY==1, stay RUN.
//   - else if hazard: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=memwb_en=1.
//     Costs one stall cycle; hazard clears next cycle since the load has advanced.
//   - else: all *_en=1, no flush/bubble.
//  FLUSH: all *_en=1, ifid_flush=1, idex_bubble=1. Load-use is ignored (squashed instr).
//   - flush_cnt decrements; next st=RUN when flush_cnt==0.
//   - mem_req & ~mem_ready in FLUSH: freeze takes priority, go MEM_WAIT.
//     The remaining flush_cnt is kept and resumed afterwards.
//  MEM_WAIT: all *_en=0, no flush/bubble.
//   - mem_ready: next st = FLUSH if flush_cnt!=0 else RUN; wait_cnt=0.
//     The pipeline advances in the following cycle.
//   - else wait_cnt++ (saturating at 255).
//     When wait_cnt==MEM_TIMEOUT, set err_timeout (sticky until rst); keep waiting.
//   - branch_taken while in MEM_WAIT is ignored.
//     Source registers are frozen, so it is re-presented after the wait.
//  Reset mid-wait or mid-flush: returns to RUN, counters cleared, same cycle rules as above.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   - adds outputs stall_cnt[31:0], flush_cnt_tot[31:0], memwait_cnt[31:0], each zeroed on rst.
//   - per cycle, increments by 1 on load-use stall, on flush/bubble cycle, and on MEM_WAIT or freeze cycle.
//   - counters wrap at 2^32.
//  HAZ_PERF_CNT_EN undefined: no counters and no ports; all other behaviour is identical.
// STRUCTURE
//  Shared package cpu_pkg:
//   - typedef enum logic [1:0] haz_state_t {RUN, FLUSH, MEM_WAIT}.
//   - localparam logic [4:0] XZR = 5'd31.
//  One sub-module: load_use_detect (pure compare of idex_rd vs ifid_rn/rm).
//  It is reused later by the forwarding unit.
// TESTING
//  1 rst=1 two cycles -> all en=0, ifid_flush=idex_bubble=1; after release, all en=1, err_timeout=0.
//  2 LDUR X2 in EX (idex_rd=2, mem_read=1), ADD reads rn=2 ->
//    one cycle with pc_en=ifid_en=0, idex_bubble=1; next cycle, all en=1.
//  3 idex_rd=31 with mem_read=1, rn=31 -> no stall.
//    rm=2, uses_rm=0, idex_rd=2 -> no stall.
//  4 BR_PENALTY=2, branch_taken one cycle ->
//    ifid_flush=idex_bubble=1 for exactly 2 cycles, pc_en stays 1.
//  5 mem_req=1, mem_ready low 4 cycles, then high ->
//    all en=0 for 5 cycles, run resumes after; err_timeout stays 0.
//  6 MEM_TIMEOUT=3, mem_ready held low 6 cycles -> err_timeout=1 after the 3rd wait cycle.
//    It stays 1 after mem_ready and clears only on rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the pipelined LEGv8 core: hazard-controller states and the zero register index.
package cpu_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } haz_state_t;

  localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags when the load in ID/EX writes a register the IF/ID instruction reads.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic       i_idex_mem_read,
  input  logic [4:0] i_idex_rd,
  input  logic [4:0] i_ifid_rn,
  input  logic [4:0] i_ifid_rm,
  input  logic       i_ifid_uses_rm,
  output logic       o_hazard
);
  logic w_rn_match;
  logic w_rm_match;

  assign w_rn_match = (i_idex_rd == i_ifid_rn);
  assign w_rm_match = i_ifid_uses_rm & (i_idex_rd == i_ifid_rm);
  // XZR reads as zero and is never written, so it can never carry a dependency.
  assign o_hazard   = i_idex_mem_read & (i_idex_rd != XZR) & (w_rn_match | w_rm_match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: load-use stalls, taken-branch squash and data-memory wait freeze.
// Optional performance counters are compiled in with HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rn,
  input  logic [4:0]  ifid_rm,
  input  logic        ifid_uses_rm,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        err_timeout,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt_tot,
  output logic [31:0] memwait_cnt,
`endif
  output logic [1:0]  dbg_st
);
  localparam logic [1:0] FLUSH_INIT = 2'(BR_PENALTY - 1);
  localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

  haz_state_t r_st, w_st_nxt;
  logic [1:0] r_flush_cnt, w_flush_nxt;
  logic [7:0] r_wait_cnt, w_wait_nxt;
  logic       r_err, w_err_nxt;
  logic       w_hazard;
  logic       w_freeze;
  logic       w_waiting;

  load_use_detect u_load_use_detect (
    .i_idex_mem_read (idex_mem_read),
    .i_idex_rd       (idex_rd),
    .i_ifid_rn       (ifid_rn),
    .i_ifid_rm       (ifid_rm),
    .i_ifid_uses_rm  (ifid_uses_rm),
    .o_hazard        (w_hazard)
  );

  assign w_freeze = mem_req & ~mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st        <= RUN;
      r_flush_cnt <= 2'd0;
      r_wait_cnt  <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_flush_nxt = r_flush_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_waiting   = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (r_st)
      RUN: begin
        if (w_freeze) begin
          w_st_nxt   = MEM_WAIT;
          w_wait_nxt = 8'd1;
          w_waiting  = 1'b1;
        end else if (branch_taken) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (BR_PENALTY > 1) begin
            w_st_nxt    = FLUSH;
            w_flush_nxt = FLUSH_INIT;
          end
        end else if (w_hazard) begin
          // Hold PC and IF/ID, let the load move on, and insert a bubble behind it.
          {idex_en, exmem_en, memwb_en} = 3'b111;
          idex_bubble = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
      FLUSH: begin
        if (w_freeze) begin
          // Remaining squash cycles are kept and resumed once memory answers.
          w_st_nxt   = MEM_WAIT;
          w_wait_nxt = 8'd1;
          w_waiting  = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          w_flush_nxt = r_flush_cnt - 2'd1;
          if (r_flush_cnt <= 2'd1) begin
            w_st_nxt    = RUN;
            w_flush_nxt = 2'd0;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_st_nxt   = (r_flush_cnt != 2'd0) ? FLUSH : RUN;
          w_wait_nxt = 8'd0;
        end else begin
          w_waiting = 1'b1;
          if (r_wait_cnt != 8'hFF) w_wait_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: w_st_nxt = RUN;
    endcase
    w_err_nxt = r_err | (w_waiting & (w_wait_nxt == TIMEOUT));
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign err_timeout = r_err;
  assign dbg_st      = r_st;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_tot, r_memwait_cnt;
  logic        w_stall_cyc;

  assign w_stall_cyc = (r_st == RUN) & ~w_freeze & ~branch_taken & w_hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt   <= 32'd0;
      r_flush_tot   <= 32'd0;
      r_memwait_cnt <= 32'd0;
    end else begin
      if (w_stall_cyc) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (ifid_flush) r_flush_tot <= r_flush_tot + 32'd1;
      if ((r_st == MEM_WAIT) | w_freeze) r_memwait_cnt <= r_memwait_cnt + 32'd1;
    end
  end

  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt_tot = r_flush_tot;
  assign memwait_cnt   = r_memwait_cnt;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: two controllers (BR_PENALTY=2/MEM_TIMEOUT=3 and defaults) share stimulus.
module tb_pipeline_hazard_ctrl;
  // Output bundle bit order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, err_timeout}
  localparam logic [7:0] V_RST = 8'b00000_110;
  localparam logic [7:0] V_RUN = 8'b11111_000;
  localparam logic [7:0] V_STL = 8'b00111_010;
  localparam logic [7:0] V_FLS = 8'b11111_110;
  localparam logic [7:0] V_FRZ = 8'b00000_000;
  localparam logic [7:0] E     = 8'b00000_001;

  logic       clk = 1'b0;
  logic       rst;
  logic       idex_mem_read;
  logic [4:0] idex_rd, ifid_rn, ifid_rm;
  logic       ifid_uses_rm, branch_taken, mem_req, mem_ready;

  logic a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble, a_exmem_en, a_memwb_en, a_err;
  logic b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble, b_exmem_en, b_memwb_en, b_err;
  logic [1:0] a_st, b_st;
  logic [7:0] w_a, w_b;

  logic [15:0] exp_q[$];
  int          id_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          n_push = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.BR_PENALTY(2), .MEM_TIMEOUT(3)) u_dut_a (
    .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush), .idex_en(a_idex_en),
    .idex_bubble(a_idex_bubble), .exmem_en(a_exmem_en), .memwb_en(a_memwb_en),
    .err_timeout(a_err), .dbg_st(a_st)
  );

  pipeline_hazard_ctrl #(.BR_PENALTY(1), .MEM_TIMEOUT(15)) u_dut_b (
    .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush), .idex_en(b_idex_en),
    .idex_bubble(b_idex_bubble), .exmem_en(b_exmem_en), .memwb_en(b_memwb_en),
    .err_timeout(b_err), .dbg_st(b_st)
  );

  assign w_a = {a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en, a_ifid_flush, a_idex_bubble, a_err};
  assign w_b = {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en, b_ifid_flush, b_idex_bubble, b_err};

  // Driver: inputs change 1ns after the rising edge; the expected bundle goes on the queue.
  task automatic apply(input logic r, input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic urm, input logic br, input logic mq,
                       input logic my, input logic [7:0] ea, input logic [7:0] eb);
    @(posedge clk);
    #1;
    rst = r; idex_mem_read = mr; idex_rd = rd; ifid_rn = rn; ifid_rm = rm;
    ifid_uses_rm = urm; branch_taken = br; mem_req = mq; mem_ready = my;
    exp_q.push_back({ea, eb});
    id_q.push_back(n_push);
    n_push++;
  endtask

  task automatic idle(input logic [7:0] ea, input logic [7:0] eb);
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb);
  endtask

  task automatic mwait(input logic br, input logic my, input logic [7:0] ea, input logic [7:0] eb);
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, br, 1'b1, my, ea, eb);
  endtask

  task automatic rst_v(input logic mq, input logic [7:0] ea, input logic [7:0] eb);
    apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, mq, 1'b0, ea, eb);
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a result mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [15:0] e;
      int          id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      n_vec++;
      if ({w_a, w_b} !== e) begin
        n_fail++;
        $display("FAIL vec %0d: dut_a got %b want %b, dut_b got %b want %b",
                 id, w_a, e[15:8], w_b, e[7:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; idex_mem_read = 1'b0; idex_rd = 5'd0; ifid_rn = 5'd0; ifid_rm = 5'd0;
    ifid_uses_rm = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset, then release
    rst_v(1'b0, V_RST, V_RST);
    rst_v(1'b0, V_RST, V_RST);
    idle(V_RUN, V_RUN);
    // load-use on Rn, then on Rm
    apply(1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_STL, V_STL);
    apply(1'b0, 1'b0, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN);
    apply(1'b0, 1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, V_STL, V_STL);
    apply(1'b0, 1'b0, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN);
    // XZR, unused Rm, and non-load producer never stall
    apply(1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN);
    apply(1'b0, 1'b1, 5'd2, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN);
    apply(1'b0, 1'b0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN);
    // taken branch: two squash cycles on dut_a, one on dut_b
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, V_FLS, V_FLS);
    idle(V_FLS, V_RUN);
    idle(V_RUN, V_RUN);
    // branch beats load-use; load-use ignored during FLUSH
    apply(1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, V_FLS, V_FLS);
    apply(1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_FLS, V_STL);
    idle(V_RUN, V_RUN);
    // memory ready in the same cycle: no freeze
    mwait(1'b0, 1'b1, V_RUN, V_RUN);
    // four wait cycles then ready: five frozen cycles; dut_a times out after its 3rd
    mwait(1'b0, 1'b0, V_FRZ, V_FRZ);
    mwait(1'b0, 1'b0, V_FRZ, V_FRZ);
    mwait(1'b0, 1'b0, V_FRZ, V_FRZ);
    mwait(1'b0, 1'b0, V_FRZ | E, V_FRZ);
    mwait(1'b0, 1'b1, V_FRZ | E, V_FRZ);
    idle(V_RUN | E, V_RUN);
    idle(V_RUN | E, V_RUN);
    // error is sticky until reset
    rst_v(1'b0, V_RST | E, V_RST);
    rst_v(1'b0, V_RST, V_RST);
    idle(V_RUN, V_RUN);
    // six wait cycles, branch during the wait is ignored
    mwait(1'b0, 1'b0, V_FRZ, V_FRZ);
    mwait(1'b0, 1'b0, V_FRZ, V_FRZ);
    mwait(1'b0, 1'b0, V_FRZ, V_FRZ);
    mwait(1'b0, 1'b0, V_FRZ | E, V_FRZ);
    mwait(1'b1, 1'b0, V_FRZ | E, V_FRZ);
    mwait(1'b0, 1'b0, V_FRZ | E, V_FRZ);
    mwait(1'b0, 1'b1, V_FRZ | E, V_FRZ);
    idle(V_RUN | E, V_RUN);
    // freeze inside FLUSH keeps the remaining squash cycle
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, V_FLS | E, V_FLS);
    mwait(1'b0, 1'b0, V_FRZ | E, V_FRZ);
    mwait(1'b0, 1'b1, V_FRZ | E, V_FRZ);
    idle(V_FLS | E, V_RUN);
    idle(V_RUN | E, V_RUN);
    // reset mid-flush and mid-wait returns to RUN
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, V_FLS | E, V_FLS);
    rst_v(1'b0, V_RST | E, V_RST);
    idle(V_RUN, V_RUN);
    mwait(1'b0, 1'b0, V_FRZ, V_FRZ);
    rst_v(1'b1, V_RST, V_RST);
    idle(V_RUN, V_RUN);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
